// File: rtl/coin_pkg.sv
// Shared coin-interface definitions: coin codes, coin value helper and
// controller state encoding used by the vending controller and change return.
package coin_pkg;

   localparam logic [1:0] COIN_NONE   = 2'b00;
   localparam logic [1:0] COIN_NICKEL = 2'b01;
   localparam logic [1:0] COIN_DIME   = 2'b10;
   localparam logic [1:0] COIN_BAD    = 2'b11;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      VEND      = 2'd1,
      CHG_PULSE = 2'd2,
      CHG_GAP   = 2'd3
   } state_t;

   // Invalid code 11 is worth nothing, so it is ignored everywhere.
   function automatic logic [1:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_NICKEL: return 2'd1;
         COIN_DIME:   return 2'd2;
         default:     return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/change_emitter.sv
// Refund counter and change sequencing: emits owed nickels as pulse/gap
// pairs of coin codes, absorbing coins that arrive while it is running.
module change_emitter
   import coin_pkg::*;
#(
   parameter int unsigned REFUND_W = 6
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load,
   input  logic                start,
   input  logic [REFUND_W-1:0] load_val,
   input  logic [1:0]          add_val,
   output logic                busy,
   output logic [1:0]          change
);

   state_t              phase;
   logic [REFUND_W-1:0] refund;
   logic [REFUND_W-1:0] base;
   logic [REFUND_W-1:0] r_next;
   logic [REFUND_W+1:0] sum;
   logic [REFUND_W+1:0] dec;

   // The pulse amount is latched on entry, so the decrement is applied on
   // leaving CHG_PULSE together with any coin that arrived meanwhile.
   always_comb begin
      base   = (phase == IDLE && load) ? load_val : refund;
      dec    = (change == COIN_DIME) ? (REFUND_W+2)'(2) : (REFUND_W+2)'(1);
      sum    = {2'b00, base} + {{REFUND_W{1'b0}}, add_val};
      if (phase == CHG_PULSE)
         sum = sum - dec;
      r_next = (sum > {2'b00, {REFUND_W{1'b1}}}) ? '1 : sum[REFUND_W-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase  <= IDLE;
         refund <= '0;
         change <= COIN_NONE;
         busy   <= 1'b0;
      end else begin
         refund <= r_next;
         case (phase)
            CHG_PULSE: begin
               phase  <= CHG_GAP;
               change <= COIN_NONE;
            end
            CHG_GAP, IDLE: begin
               if ((phase == CHG_GAP || start) && r_next != '0) begin
                  phase  <= CHG_PULSE;
                  change <= (r_next >= REFUND_W'(2)) ? COIN_DIME : COIN_NICKEL;
                  busy   <= 1'b1;
               end else begin
                  phase  <= IDLE;
                  change <= COIN_NONE;
                  busy   <= 1'b0;
               end
            end
            default: begin
               phase  <= IDLE;
               change <= COIN_NONE;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/newspaper_change_dispenser.sv
// Coin-operated newspaper vending controller: credits coins, pulses a vend
// and hands surplus or cancelled credit to the change emitter.
module newspaper_change_dispenser
   import coin_pkg::*;
#(
   parameter int unsigned PRICE    = 3,
   parameter int unsigned REFUND_W = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] coin,
   input  logic       cancel,
   output logic       newspaper,
   output logic [1:0] change,
   output logic       busy
);

   state_t              state;
   logic [3:0]          credit;
   logic [4:0]          total;
   logic                accept;
   logic                do_vend;
   logic                do_cancel;
   logic                em_load;
   logic                em_start;
   logic                em_busy;
   logic [REFUND_W-1:0] em_load_val;
   logic [1:0]          em_add;

   // Coins seen while vending or returning change go straight to the refund.
   always_comb begin
      accept      = (state == IDLE) && !em_busy;
      total       = {1'b0, credit} + {3'b000, coin_value(coin)};
      do_cancel   = accept && cancel && (total != '0);
      do_vend     = accept && !cancel && (total >= 5'(PRICE));
      em_load     = do_cancel || do_vend;
      em_start    = do_cancel || (state == VEND);
      em_load_val = do_cancel ? REFUND_W'(total) : REFUND_W'(total - 5'(PRICE));
      em_add      = accept ? 2'd0 : coin_value(coin);
      busy        = (state == VEND) || em_busy;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         credit    <= '0;
         newspaper <= 1'b0;
      end else begin
         newspaper <= do_vend;
         if (state == VEND)
            state <= IDLE;
         else if (do_vend)
            state <= VEND;
         if (do_vend || do_cancel)
            credit <= '0;
         else if (accept)
            credit <= total[3:0];
      end
   end

   change_emitter #(
      .REFUND_W(REFUND_W)
   ) u_change_emitter (
      .clock   (clock),
      .reset   (reset),
      .load    (em_load),
      .start   (em_start),
      .load_val(em_load_val),
      .add_val (em_add),
      .busy    (em_busy),
      .change  (change)
   );

endmodule

// File: doc/newspaper_change_dispenser.md
# newspaper_change_dispenser

Coin-operated newspaper vending controller that returns change, the return side of the 2-bit coin interface. It accepts coin codes from the coin slot, pulses `newspaper` once the price is reached, and emits surplus credit back as coin codes in the same encoding on a `change` output. Downstream coin-return hardware and benches can reuse the coin-slot receive logic to count the returned coins.

## Interface
- `PRICE`, default 3: newspaper price in nickels (3 = 15 cents); legal range 1..15.
- `REFUND_W`, default 6: width of the refund counter, in nickels.
- `clock` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `coin` input 2: 00 none, 01 nickel, 10 dime, 11 invalid. Sampled every rising edge. One cycle of non-00 is one coin.
- `cancel` input 1: coin-return request, sampled every rising edge.
- `newspaper` output 1: one-cycle vend pulse.
- `change` output 2: returned coin, same encoding as `coin`; 11 is never driven.
- `busy` output 1: high while vending or returning change.

## Operation
- Credit register: counts nickels accepted toward the current sale, range 0..PRICE-1 when idle.
- Refund counter: `REFUND_W` bits, saturating, counts nickels owed to the customer.
- State machine has four states: IDLE, VEND, CHG_PULSE, CHG_GAP.
- IDLE, on each edge:
  - A nickel adds 1 and a dime adds 2.
  - If `cancel` is low and credit plus coin is at least PRICE: refund is loaded with (credit + coin − PRICE), credit is cleared, and the state goes to VEND.
  - If `cancel` is high and credit plus coin is greater than 0: the whole amount goes to refund, credit is cleared, no vend occurs, and the state goes to CHG_PULSE.
  - If `cancel` is high and the total is 0, the cancel is ignored.
  - Otherwise credit is updated and the state stays IDLE.
- VEND lasts exactly one cycle with `newspaper`=1. Next state is CHG_PULSE if refund is nonzero, else IDLE.
- CHG_PULSE lasts one cycle. It drives `change`=10 and subtracts 2 from refund if refund ≥ 2; otherwise it drives 01 and subtracts 1. Next state is CHG_GAP.
- CHG_GAP lasts one cycle with `change`=00. Next state is CHG_PULSE if refund is nonzero, else IDLE.
- Coins arriving outside IDLE are not credited. Their value is added to refund, so they are returned in the same sequence.
- `cancel` is ignored outside IDLE.
- Coin code 11 is ignored in every state.
- `busy` = 1 in VEND, CHG_PULSE and CHG_GAP.

## Timing
- Reset values: state IDLE, credit 0, refund 0, `newspaper`=0, `change`=00, `busy`=0. Reset takes effect at the next rising edge.
- Reset mid-vend or mid-change abandons all owed change. Outputs are 0 and the state is IDLE in the cycle after that edge.
- All outputs are registered and decoded from state only, with no combinational path from input to output.
- Completing coin or cancel sampled at edge N:
  - `newspaper` is high in cycle N+1.
  - The first change pulse is in cycle N+2 after a vend, or N+1 after a cancel.
- Returned coins are spaced two cycles apart: pulse, then gap.
- Returning R nickels of refund takes 2·⌈R/2⌉ cycles. `busy` falls in the cycle after the last gap.
- Coins arriving in the final CHG_GAP cycle still increment refund, so the machine stays in CHG_PULSE/CHG_GAP rather than returning to IDLE.

## Structure
- Shared package `coin_pkg` holds:
  - coin code constants `COIN_NONE`=00, `COIN_NICKEL`=01, `COIN_DIME`=10, `COIN_BAD`=11;
  - a function converting a coin code to its value in nickels;
  - the state encoding constants.
- One sub-module, `change_emitter`. It owns the refund counter and the CHG_PULSE/CHG_GAP sequencing. Its handshake is a load/add value input, a `busy` output and the `change` output.
- Top-level credit and vend logic stays in `newspaper_change_dispenser`.

## Test plan
- Three nickels, each held one cycle with idle gaps:
  - `newspaper` is high for exactly one cycle, the cycle after the third nickel.
  - `change` stays 00.
  - `busy` is high for one cycle.
- Nickel then dime: one vend pulse, no change pulses, credit 0 afterwards.
- Dime then dime: vend pulse in cycle N+1, `change`=01 in cycle N+2, 00 in N+3, and `busy` low in N+4.
- Dime, then `cancel` alone, then nickel with `cancel` high in the same cycle:
  - the first cancel returns a single 10 with no vend;
  - the second cancel returns 01 only.
- During a two-dime refund sequence (`cancel` after 2 dimes with PRICE=5), a nickel is inserted in the middle:
  - the output sequence is 10, gap, 10, gap, 01, gap;
  - the nickel is not credited afterwards.
- Reset asserted during CHG_PULSE:
  - all outputs are 0 the following cycle and the refund is lost;
  - a subsequent three-nickel sale works normally.
- `coin`=11 in IDLE and while busy: no credit, no refund, no output change.
